// File: rtl/fft8_pkg.sv
// Shared types and constants for the 8-point FFT/IFFT scheduler.
package fft8_pkg;

    localparam int DW = 9;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMPUTE,
        UNLOAD
    } state_t;

    // Q8 twiddle magnitude (181/256 ~ 1/sqrt2) and the integer twiddle set
    localparam logic signed [DW-1:0] TW_Q8_POS = 9'sd181;
    localparam logic signed [DW-1:0] TW_Q8_NEG = -9'sd181;
    localparam logic signed [DW-1:0] TW_ONE    = 9'sd1;
    localparam logic signed [DW-1:0] TW_ZERO   = 9'sd0;
    localparam logic signed [DW-1:0] TW_MONE   = -9'sd1;

    function automatic logic [2:0] bitrev3(input logic [2:0] n);
        return {n[0], n[1], n[2]};
    endfunction

endpackage

// File: rtl/fft8_sched_if.sv
// Stream/control bundle between a host and the fft8_sched scheduler.
interface fft8_sched_if;

    logic                            start;
    logic                            inv;
    logic                            in_valid;
    logic signed [fft8_pkg::DW-1:0]  in_re;
    logic signed [fft8_pkg::DW-1:0]  in_im;
    logic                            in_ready;
    logic                            out_valid;
    logic signed [fft8_pkg::DW-1:0]  out_re;
    logic signed [fft8_pkg::DW-1:0]  out_im;
    logic                            out_ready;
    logic                            busy;
    logic                            done;

    modport master (
        output start, inv, in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, busy, done
    );

    modport slave (
        input  start, inv, in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im, busy, done
    );

endinterface

// File: rtl/fft8_bfly.sv
// Combinational radix-2 complex butterfly: x = a + W*b, y = a - W*b, all wrapping.
module fft8_bfly
    import fft8_pkg::*;
(
    input  logic signed [DW-1:0] a_re,
    input  logic signed [DW-1:0] a_im,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_im,
    input  logic signed [DW-1:0] wr,
    input  logic signed [DW-1:0] wi,
    input  logic                 scaled,
    output logic signed [DW-1:0] x_re,
    output logic signed [DW-1:0] x_im,
    output logic signed [DW-1:0] y_re,
    output logic signed [DW-1:0] y_im
);

    // 17 bits suffice: bits [16:8] and [8:0] match those of the full 18-bit product
    logic signed [2*DW-2:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [DW-1:0]   s_rr, s_ii, s_ri, s_ir;
    logic signed [DW-1:0]   t_re, t_im;

    always_comb begin
        p_rr = (2*DW-1)'(wr) * (2*DW-1)'(b_re);
        p_ii = (2*DW-1)'(wi) * (2*DW-1)'(b_im);
        p_ri = (2*DW-1)'(wr) * (2*DW-1)'(b_im);
        p_ir = (2*DW-1)'(wi) * (2*DW-1)'(b_re);

        s_rr = scaled ? p_rr[2*DW-2:DW-1] : p_rr[DW-1:0];
        s_ii = scaled ? p_ii[2*DW-2:DW-1] : p_ii[DW-1:0];
        s_ri = scaled ? p_ri[2*DW-2:DW-1] : p_ri[DW-1:0];
        s_ir = scaled ? p_ir[2*DW-2:DW-1] : p_ir[DW-1:0];

        t_re = s_rr - s_ii;
        t_im = s_ri + s_ir;

        x_re = a_re + t_re;
        x_im = a_im + t_im;
        y_re = a_re - t_re;
        y_im = a_im - t_im;
    end

endmodule

// File: rtl/fft8_sched.sv
// Iterative 8-point radix-2 DIT FFT/IFFT: load, 12 in-place butterflies, unload.
module fft8_sched
    import fft8_pkg::*;
#(
    parameter bit SCALE_INV = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    fft8_sched_if.slave  bus
);

    state_t               state;
    logic [2:0]           in_cnt;
    logic [3:0]           bf_cnt;
    logic [2:0]           out_cnt;
    logic                 inv_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic                 busy_q;
    logic                 done_q;

    logic signed [DW-1:0] x_re [8];
    logic signed [DW-1:0] x_im [8];

    logic [1:0]           stg;
    logic [2:0]           bidx, half, pos, addr_a, addr_b;
    logic [1:0]           tw_k;
    logic signed [DW-1:0] wr, wi_rom, wi;
    logic                 tw_scaled;
    logic signed [DW-1:0] bf_x_re, bf_x_im, bf_y_re, bf_y_im;
    logic signed [DW-1:0] rd_re, rd_im;

    always_comb begin
        stg    = bf_cnt[3:2];
        bidx   = {1'b0, bf_cnt[1:0]};
        half   = 3'd1 << stg;
        pos    = bidx & (half - 3'd1);
        addr_a = (((bidx >> stg) << stg) << 1) + pos;
        addr_b = addr_a + half;
        tw_k   = 2'(pos << (2'd2 - stg));
    end

    always_comb begin
        wr        = TW_ONE;
        wi_rom    = TW_ZERO;
        tw_scaled = 1'b0;
        case (tw_k)
            2'd0: begin wr = TW_ONE;    wi_rom = TW_ZERO;   tw_scaled = 1'b0; end
            2'd1: begin wr = TW_Q8_POS; wi_rom = TW_Q8_NEG; tw_scaled = 1'b1; end
            2'd2: begin wr = TW_ZERO;   wi_rom = TW_MONE;   tw_scaled = 1'b0; end
            2'd3: begin wr = TW_Q8_NEG; wi_rom = TW_Q8_NEG; tw_scaled = 1'b1; end
            default: ;
        endcase
        wi = inv_q ? -wi_rom : wi_rom;
    end

    fft8_bfly u_bfly (
        .a_re   (x_re[addr_a]),
        .a_im   (x_im[addr_a]),
        .b_re   (x_re[addr_b]),
        .b_im   (x_im[addr_b]),
        .wr     (wr),
        .wi     (wi),
        .scaled (tw_scaled),
        .x_re   (bf_x_re),
        .x_im   (bf_x_im),
        .y_re   (bf_y_re),
        .y_im   (bf_y_im)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_cnt      <= '0;
            bf_cnt      <= '0;
            out_cnt     <= '0;
            inv_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) begin
                x_re[i] <= '0;
                x_im[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state      <= LOAD;
                        inv_q      <= bus.inv;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        in_cnt     <= '0;
                    end
                end
                LOAD: begin
                    if (bus.in_valid) begin
                        x_re[bitrev3(in_cnt)] <= bus.in_re;
                        x_im[bitrev3(in_cnt)] <= bus.in_im;
                        in_cnt                <= in_cnt + 3'd1;
                        if (in_cnt == 3'd7) begin
                            state      <= COMPUTE;
                            in_ready_q <= 1'b0;
                            bf_cnt     <= '0;
                        end
                    end
                end
                COMPUTE: begin
                    x_re[addr_a] <= bf_x_re;
                    x_im[addr_a] <= bf_x_im;
                    x_re[addr_b] <= bf_y_re;
                    x_im[addr_b] <= bf_y_im;
                    bf_cnt       <= bf_cnt + 4'd1;
                    if (bf_cnt == 4'd11) begin
                        state       <= UNLOAD;
                        bf_cnt      <= '0;
                        out_cnt     <= '0;
                        out_valid_q <= 1'b1;
                    end
                end
                UNLOAD: begin
                    if (bus.out_ready) begin
                        out_cnt <= out_cnt + 3'd1;
                        if (out_cnt == 3'd7) begin
                            state       <= IDLE;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output reads the register file directly so the final butterfly write is visible at once
    always_comb begin
        rd_re = x_re[out_cnt];
        rd_im = x_im[out_cnt];
        if (inv_q && SCALE_INV) begin
            rd_re = rd_re >>> 3;
            rd_im = rd_im >>> 3;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.out_re    = out_valid_q ? rd_re : '0;
    assign bus.out_im    = out_valid_q ? rd_im : '0;

endmodule

// File: tb/tb_fft8_sched.sv
// Scoreboard bench for fft8_sched against a behavioural radix-2 reference.
module tb_fft8_sched;

    typedef int vec_t [8];
    typedef struct {
        int re;
        int im;
        int tol;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   or_mode = 0;
    int   ph = 0;
    exp_t exp_q [$];

    fft8_sched_if bus ();

    fft8_sched #(.SCALE_INV(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic check_tol(input string name, input int act, input int req, input int tol);
        int d;
        checks++;
        d = act - req;
        if (d < 0) d = -d;
        if (d > tol) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d tol=%0d", name, act, req, tol);
        end
    endtask

    function automatic int wrap9(input int v);
        int m;
        m = v & 511;
        return (m >= 256) ? m - 512 : m;
    endfunction

    // Decimation-in-time FFT with twiddles held uniformly in Q8 (integer ones exact)
    function automatic void fft_ref(input vec_t xr, input vec_t xi, input bit inv,
                                    output vec_t yr, output vec_t yi);
        int ar [8];
        int ai [8];
        int twr [4];
        int twi [4];
        int half, pos, a, bb, k, w_r, w_i, tr, ti, nar, nai;
        twr[0] = 256; twr[1] = 181;  twr[2] = 0;    twr[3] = -181;
        twi[0] = 0;   twi[1] = -181; twi[2] = -256; twi[3] = -181;
        for (int n = 0; n < 8; n++) begin
            ar[((n & 1) << 2) | (n & 2) | ((n >> 2) & 1)] = xr[n];
            ai[((n & 1) << 2) | (n & 2) | ((n >> 2) & 1)] = xi[n];
        end
        for (int s = 0; s < 3; s++) begin
            for (int b = 0; b < 4; b++) begin
                half = 1 << s;
                pos  = b & (half - 1);
                a    = ((b >> s) * 2 * half) + pos;
                bb   = a + half;
                k    = pos << (2 - s);
                w_r  = twr[k];
                w_i  = inv ? -twi[k] : twi[k];
                tr   = wrap9(((w_r * ar[bb]) >>> 8) - ((w_i * ai[bb]) >>> 8));
                ti   = wrap9(((w_r * ai[bb]) >>> 8) + ((w_i * ar[bb]) >>> 8));
                nar  = wrap9(ar[a] + tr);
                nai  = wrap9(ai[a] + ti);
                ar[bb] = wrap9(ar[a] - tr);
                ai[bb] = wrap9(ai[a] - ti);
                ar[a]  = nar;
                ai[a]  = nai;
            end
        end
        for (int n = 0; n < 8; n++) begin
            yr[n] = inv ? (ar[n] >>> 3) : ar[n];
            yi[n] = inv ? (ai[n] >>> 3) : ai[n];
        end
    endfunction

    // Downstream acceptance pattern, updated just after each rising edge
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                0: bus.out_ready = 1'b1;
                1: begin
                    bus.out_ready = (ph == 0) || (ph == 3);
                    ph = (ph + 1) % 4;
                end
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on every output handshake, checks stalls and done
    logic held_v = 1'b0;
    int   held_re, held_im;
    logic prev_done = 1'b0;
    exp_t e;

    always @(negedge clk) begin
        if (!rst_n) begin
            held_v    = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (held_v && bus.out_valid) begin
                check("stall_re", int'(bus.out_re), held_re);
                check("stall_im", int'(bus.out_im), held_im);
            end
            held_v = 1'b0;
            if (bus.out_valid && !bus.out_ready) begin
                held_v  = 1'b1;
                held_re = int'(bus.out_re);
                held_im = int'(bus.out_im);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_tol("out_re", int'(bus.out_re), e.re, e.tol);
                    check_tol("out_im", int'(bus.out_im), e.im, e.tol);
                end
            end
            if (bus.done) begin
                check("done_width", int'(prev_done), 0);
                check("done_idle", int'(bus.busy), 0);
                check("done_drained", exp_q.size(), 0);
            end
            prev_done = bus.done;
        end
    end

    task automatic feed(input vec_t xr, input vec_t xi, input bit gap);
        int r;
        for (int n = 0; n < 8; n++) begin
            if (gap) begin
                bus.in_valid = 1'b0;
                r = $urandom_range(0, 2);
                for (int j = 0; j < r; j++) begin
                    @(posedge clk);
                    #1;
                end
            end
            bus.in_valid = 1'b1;
            bus.in_re    = 9'(xr[n]);
            bus.in_im    = 9'(xi[n]);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_re    = 9'($urandom_range(0, 511));
        bus.in_im    = 9'($urandom_range(0, 511));
    endtask

    task automatic check_latency(input bit pulse);
        for (int i = 1; i <= 11; i++) begin
            @(posedge clk);
            #1;
            bus.start    = pulse && (i == 4);
            bus.in_valid = pulse && (i == 4);
        end
        check("ov_before_l12", int'(bus.out_valid), 0);
        check("busy_compute", int'(bus.busy), 1);
        check("ir_compute", int'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        check("ov_at_l12", int'(bus.out_valid), 1);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", int'(seen), 1);
    endtask

    task automatic run_frame(input vec_t xr, input vec_t xi, input bit inv, input bit gap,
                             input bit pulse, input vec_t er, input vec_t ei, input int tol);
        bus.start = 1'b1;
        bus.inv   = inv;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.inv   = ~inv;
        check("ir_load", int'(bus.in_ready), 1);
        check("busy_load", int'(bus.busy), 1);
        for (int n = 0; n < 8; n++) exp_q.push_back('{er[n], ei[n], tol});
        feed(xr, xi, gap);
        check_latency(pulse);
        wait_done();
    endtask

    vec_t zr, imp, one, dc, dcr, rv, fr, fi, yr, yi, rr, ri;

    initial begin
        bus.start    = 1'b0;
        bus.inv      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_re    = '0;
        bus.in_im    = '0;
        zr  = '{0, 0, 0, 0, 0, 0, 0, 0};
        imp = '{1, 0, 0, 0, 0, 0, 0, 0};
        one = '{1, 1, 1, 1, 1, 1, 1, 1};
        dc  = '{10, 10, 10, 10, 10, 10, 10, 10};
        dcr = '{80, 0, 0, 0, 0, 0, 0, 0};
        rv  = '{15, 9, 19, -15, 0, -30, 9, -9};

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_in_ready", int'(bus.in_ready), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_out_re", int'(bus.out_re), 0);
        check("rst_out_im", int'(bus.out_im), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        or_mode = 0;
        run_frame(imp, zr, 1'b0, 1'b0, 1'b0, one, zr, 0);
        run_frame(dc, zr, 1'b0, 1'b0, 1'b0, dcr, zr, 0);

        fft_ref(rv, zr, 1'b0, fr, fi);
        fr[0] = -2;  fi[0] = 0;
        fr[4] = 88;  fi[4] = 0;
        fr[2] = -13; fi[2] = -3;
        fr[6] = -13; fi[6] = 3;
        or_mode = 1;
        ph = 0;
        run_frame(rv, zr, 1'b0, 1'b1, 1'b1, fr, fi, 0);

        or_mode = 2;
        run_frame(fr, fi, 1'b1, 1'b1, 1'b0, rv, zr, 2);

        or_mode = 0;
        bus.start = 1'b1;
        bus.inv   = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        feed(dc, zr, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_busy", int'(bus.busy), 0);
        check("arst_in_ready", int'(bus.in_ready), 0);
        check("arst_out_valid", int'(bus.out_valid), 0);
        check("arst_done", int'(bus.done), 0);
        check("arst_out_re", int'(bus.out_re), 0);
        check("arst_out_im", int'(bus.out_im), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_frame(imp, zr, 1'b0, 1'b0, 1'b0, one, zr, 0);

        for (int t = 0; t < 6; t++) begin
            bit inv_t;
            inv_t   = 1'($urandom_range(0, 1));
            or_mode = $urandom_range(0, 2);
            for (int n = 0; n < 8; n++) begin
                rr[n] = wrap9($urandom_range(0, 511));
                ri[n] = wrap9($urandom_range(0, 511));
            end
            fft_ref(rr, ri, inv_t, yr, yi);
            run_frame(rr, ri, inv_t, 1'($urandom_range(0, 1)), 1'b0, yr, yi, 0);
        end

        repeat (3) @(posedge clk);
        check("final_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
